mpu_transpose_stream: RTL and testbench
=======================================

MPU_TRANSPOSE_STREAM -- requirements
Module: mpu_transpose_stream

Interface
REQ-001 SHALL have parameter N, default 5, the matrix dimension (N x N).
REQ-002 SHALL have parameter W, default 8, the element width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, the row-beat valid signal.
REQ-006 SHALL have port in_ready, output, 1 bit, the block accepts a row beat.
REQ-007 SHALL have port in_row, input, N*W bits, one matrix row; bits [W*j+W-1:W*j] carry element [r][j].
REQ-008 SHALL have port out_valid, output, 1 bit, a transposed-row beat is present.
REQ-009 SHALL have port out_ready, input, 1 bit, the consumer accepts the beat.
REQ-010 SHALL have port out_row, output, N*W bits, column c of the stored matrix; bits [W*j+W-1:W*j] carry element [j][c].
REQ-011 SHALL have port out_index, output, 3 bits, the current column index c.
REQ-012 SHALL have port out_last, output, 1 bit, asserted with the beat where c = N-1.
REQ-013 SHALL have port flush, input, 1 bit, a synchronous abort of the current matrix.

Function
REQ-014 SHALL implement a two-state FSM: LOAD (accept rows) and DRAIN (emit columns).
REQ-015 In LOAD, in_ready SHALL be 1 and out_valid SHALL be 0; in DRAIN, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 A handshake (in_valid and in_ready high at a clock edge) SHALL write in_row into buffer row row_cnt and increment row_cnt.
REQ-017 The handshake with row_cnt = N-1 SHALL clear row_cnt and move to DRAIN, so out_valid rises in the next cycle (1-cycle latency).
REQ-018 In DRAIN, out_row SHALL be the combinational column col_cnt of the buffer, and out_index SHALL equal col_cnt.
REQ-019 out_row, out_index and out_last SHALL hold stable while out_valid is high and out_ready is low.
REQ-020 An output handshake SHALL increment col_cnt; the handshake with col_cnt = N-1 SHALL clear col_cnt and return to LOAD, so in_ready rises in the next cycle.
REQ-021 There SHALL be no overlap of load and drain: one buffer, with no bypass path from in_row to out_row.
REQ-022 flush high SHALL, at the next edge, force LOAD and clear row_cnt and col_cnt; it discards a partial load or remaining drain beats and leaves buffer contents unchanged.
REQ-023 flush SHALL take priority over a simultaneous input or output handshake, which is then ignored.
REQ-024 in_valid while in DRAIN SHALL have no effect; out_ready while in LOAD SHALL have no effect.
REQ-025 The data path SHALL be a pure permutation with no arithmetic; elements pass bit-exact.

Reset
REQ-026 rst SHALL force LOAD, row_cnt = 0, col_cnt = 0, and all buffer elements to 0.
REQ-027 While rst is high, in_ready, out_valid and out_last SHALL be 0; out_row and out_index SHALL be 0.
REQ-028 rst SHALL take priority over flush and over all handshakes, including mid-load and mid-drain.

Structure
REQ-029 Package mpu_pkg SHALL hold N, W, the element typedef (W bits), the row typedef (N*W bits), the matrix typedef (N x N elements) and the state enum {LOAD, DRAIN}.
REQ-030 Column extraction SHALL be one combinational sub-module, mpu_column_select (matrix and index in, row out), instantiated once.

Verification
REQ-031 The bench SHALL cover back-to-back transfer: load element[r][j] = 8'h(r<<4 | j) with in_valid held 5 cycles -> out_valid one cycle later; beat c = {8'h4c, 8'h3c, 8'h2c, 8'h1c, 8'h0c} (MSB to LSB) for c = 0..4; out_last only at c = 4; in_ready back one cycle after.
REQ-032 The bench SHALL cover output backpressure: out_ready low for 3 cycles during beat c = 2 -> out_row, out_index and out_last stay constant, and no beat is skipped or duplicated.
REQ-033 The bench SHALL cover input gaps: in_valid toggled 1/0 across 10 cycles -> the 5 rows are captured in order, and the drain matches REQ-031.
REQ-034 The bench SHALL cover flush mid-load: flush after 3 rows, then a full new matrix of all 8'hAA -> 5 beats of all 8'hAA, with no stale rows.
REQ-035 The bench SHALL cover reset mid-drain: rst during beat c = 1 -> out_valid = 0 and in_ready = 0 while rst is high; in_ready = 1 after rst falls; the next drain after a full load of zeros is all zeros.
REQ-036 The bench SHALL cover a simultaneous flush and output handshake: at c = 3 -> the handshake is ignored, the next state is LOAD, and no out_last is seen.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared types and constants for the streaming matrix transpose block.
// Holds the default geometry, element/row/matrix types and the control FSM encoding.
package mpu_pkg;

    localparam int unsigned N     = 5;
    localparam int unsigned W     = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [W-1:0]                  elem_t;
    typedef logic [N*W-1:0]                row_t;
    typedef logic [N-1:0][N-1:0][W-1:0]    matrix_t;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Counter width for an n-entry index; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpu_column_select.sv
// Combinational column extractor: returns column idx_i of an N x N matrix as a packed row.
// Element [j][idx_i] lands in bits [W*j+W-1:W*j]; out-of-range indices return zero.
module mpu_column_select #(
    parameter int unsigned N  = mpu_pkg::N,
    parameter int unsigned W  = mpu_pkg::W,
    parameter int unsigned IW = mpu_pkg::cnt_width(mpu_pkg::N)
) (
    input  logic [N-1:0][N-1:0][W-1:0] mat_i,
    input  logic [IW-1:0]              idx_i,
    output logic [N*W-1:0]             row_o
);

    // Compare-and-select mux keeps every array access at a constant, in-range index.
    always_comb begin
        row_o = '0;
        for (int j = 0; j < int'(N); j++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (idx_i == IW'(c)) begin
                    row_o[W*j +: W] = mat_i[j][c];
                end
            end
        end
    end

endmodule

// File: rtl/mpu_transpose_stream.sv
// Streaming N x N transpose: loads N row beats into one buffer, then emits its N columns.
// Load and drain never overlap; flush aborts the current matrix without touching the buffer.
module mpu_transpose_stream #(
    parameter int unsigned N = mpu_pkg::N,
    parameter int unsigned W = mpu_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_row,
    output logic [2:0]     out_index,
    output logic           out_last,
    input  logic           flush
);

    localparam int unsigned CW = mpu_pkg::cnt_width(N);

    mpu_pkg::state_e               state_q, state_d;
    logic [CW-1:0]                 row_q, row_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [N-1:0][N-1:0][W-1:0]    mat_q;
    logic                          wr_en;
    logic                          drain_act;
    logic [N*W-1:0]                col_row;

    mpu_column_select #(
        .N  (N),
        .W  (W),
        .IW (CW)
    ) u_col_sel (
        .mat_i (mat_q),
        .idx_i (col_q),
        .row_o (col_row)
    );

    // State, counters and buffer; reset wins over flush and both handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= mpu_pkg::LOAD;
            row_q   <= '0;
            col_q   <= '0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            for (int r = 0; r < int'(N); r++) begin
                if (wr_en && (row_q == CW'(r))) begin
                    mat_q[r] <= in_row;
                end
            end
        end
    end

    // Next-state, buffer write enable and handshake-facing outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en     = 1'b0;
        drain_act = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_row   = '0;
        out_index = '0;
        out_last  = 1'b0;

        if (flush) begin
            state_d = mpu_pkg::LOAD;
            row_d   = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                mpu_pkg::LOAD: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (row_q == CW'(N - 1)) begin
                            row_d   = '0;
                            state_d = mpu_pkg::DRAIN;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end
                end
                mpu_pkg::DRAIN: begin
                    if (out_ready) begin
                        if (col_q == CW'(N - 1)) begin
                            col_d   = '0;
                            state_d = mpu_pkg::LOAD;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                default: state_d = mpu_pkg::LOAD;
            endcase
        end

        // Outputs are forced quiet while reset is asserted, whatever the current state.
        drain_act = !rst && (state_q == mpu_pkg::DRAIN);
        in_ready  = !rst && (state_q == mpu_pkg::LOAD);
        out_valid = drain_act;
        if (drain_act) begin
            out_row   = col_row;
            out_index = 3'(col_q);
            out_last  = (col_q == CW'(N - 1));
        end
    end

endmodule

// File: tb/tb_mpu_transpose_stream.sv
// Directed self-checking bench for mpu_transpose_stream (N=5, W=8).
// Each task drives one scenario and compares against hand-derived expected beats.
module tb_mpu_transpose_stream;

    localparam int unsigned N = 5;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_row;
    logic [2:0]     out_index;
    logic           out_last;
    logic           flush;

    int n_tests = 0;
    int n_fail  = 0;

    mpu_transpose_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_index (out_index),
        .out_last  (out_last),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // mode 0: element[r][j] = r<<4 | j; mode 1: all 8'hAA; otherwise all zero.
    function automatic logic [N*W-1:0] row_of(input int mode, input int r);
        logic [N*W-1:0] v;
        v = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (mode == 0)      v[W*j +: W] = 8'(r * 16 + j);
            else if (mode == 1) v[W*j +: W] = 8'hAA;
        end
        return v;
    endfunction

    // Column c of the matrix built by row_of: element[j][c] in lane j.
    function automatic logic [N*W-1:0] col_of(input int mode, input int c);
        logic [N*W-1:0] v;
        v = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (mode == 0)      v[W*j +: W] = 8'(j * 16 + c);
            else if (mode == 1) v[W*j +: W] = 8'hAA;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Five consecutive row beats, then expect DRAIN one cycle after the last handshake.
    task automatic load_b2b(input int mode);
        for (int r = 0; r < int'(N); r++) begin
            in_row   = row_of(mode, r);
            in_valid = 1'b1;
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready r=%0d got in_ready=%b expected 1", r, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        in_row   = '0;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_done got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
        end
    endtask

    // Full drain from beat 0, optional stall at stall_c, optional junk on the input side.
    task automatic drain(input int mode, input int stall_c, input int stall_n, input logic junk_in);
        logic [N*W-1:0] exp_row;
        for (int c = 0; c < int'(N); c++) begin
            exp_row = col_of(mode, c);
            if (junk_in) begin
                in_valid = 1'b1;
                in_row   = '1;
            end
            if (c == stall_c) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    #1;
                    n_tests++;
                    if ({out_valid, out_index, out_last, out_row} !== {1'b1, 3'(c), (c == int'(N) - 1), exp_row}) begin
                        n_fail++;
                        $display("FAIL stall_hold c=%0d k=%0d got v=%b idx=%0d last=%b row=%h expected idx=%0d row=%h",
                                 c, k, out_valid, out_index, out_last, out_row, c, exp_row);
                    end
                    tick();
                end
            end
            out_ready = 1'b1;
            #1;
            n_tests++;
            if ({out_valid, out_index, out_last, out_row} !== {1'b1, 3'(c), (c == int'(N) - 1), exp_row}) begin
                n_fail++;
                $display("FAIL drain_beat c=%0d got v=%b idx=%0d last=%b row=%h expected idx=%0d last=%b row=%h",
                         c, out_valid, out_index, out_last, out_row, c, (c == int'(N) - 1), exp_row);
            end
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_last} !== 3'b010) begin
            n_fail++;
            $display("FAIL drain_done got out_valid=%b in_ready=%b out_last=%b expected 0 1 0",
                     out_valid, in_ready, out_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_last, out_index, out_row} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b v=%b last=%b idx=%0d row=%h expected all 0",
                     in_ready, out_valid, out_last, out_index, out_row);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        load_b2b(0);
        drain(0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_b2b(0);
        drain(0, 2, 3, 1'b0);
    endtask

    // Valid on even cycles only, junk data in the gaps; out_ready held high while loading.
    task automatic test_input_gaps();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                in_valid = 1'b1;
                in_row   = row_of(0, k / 2);
            end else begin
                in_valid = 1'b0;
                in_row   = '1;
            end
            out_ready = (k < 9);
            #1;
            n_tests++;
            if (in_ready !== (k < 9)) begin
                n_fail++;
                $display("FAIL gap_ready k=%0d got in_ready=%b expected %b", k, in_ready, (k < 9));
            end
            tick();
        end
        in_valid = 1'b0;
        in_row   = '0;
        #1;
        n_tests++;
        if ({out_valid, out_index} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL gap_drain_start got out_valid=%b idx=%0d expected 1 0", out_valid, out_index);
        end
        drain(0, -1, 0, 1'b1);
    endtask

    // Flush after three rows, with a coincident input beat that must be dropped.
    task automatic test_flush_load();
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1;
            in_row   = row_of(0, r);
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_row   = {N{8'h55}};
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_load_state got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        load_b2b(1);
        drain(1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_drain();
        load_b2b(0);
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_last, out_index, out_row} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_drain got v=%b rdy=%b last=%b idx=%0d row=%h expected all 0",
                     out_valid, in_ready, out_last, out_index, out_row);
        end
        tick();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_held got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_after got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        load_b2b(2);
        drain(2, -1, 0, 1'b0);
    endtask

    // Flush coincident with the beat-3 handshake: no beat 4, counters back to zero.
    task automatic test_flush_drain();
        load_b2b(0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        flush = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, out_index, out_last} !== {1'b1, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_beat3 got v=%b idx=%0d last=%b expected 1 3 0", out_valid, out_index, out_last);
        end
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_last} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_drain_state got v=%b rdy=%b last=%b expected 0 1 0", out_valid, in_ready, out_last);
        end
        load_b2b(1);
        drain(1, -1, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_input_gaps();
        test_flush_load();
        test_reset_drain();
        test_flush_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
